// File: rtl/fft_frame_sched_if.sv
// Handshake and data bundle between the frame scheduler, the sample source
// and the burst FFT core.
//   src_*   : streaming complex-sample source ({imag, real})
//   cfg_*   : per-frame direction config towards the core
//   s_axi_* : core input stream
//   m_axi_* : core output stream, observed only (valid/last)
// master: the scheduler side; slave: the source/core side.
interface fft_frame_sched_if #(
  parameter int DATA_WIDTH = 16
);
  logic                    src_valid;
  logic [2*DATA_WIDTH-1:0] src_data;
  logic                    src_ready;

  logic                    cfg_valid;
  logic                    cfg_inverse;
  logic                    cfg_ready;

  logic                    s_axi_valid;
  logic [2*DATA_WIDTH-1:0] s_axi_data;
  logic                    s_axi_last;
  logic                    s_axi_ready;

  logic                    m_axi_valid;
  logic                    m_axi_last;

  modport master (
    input  src_valid, src_data, cfg_ready, s_axi_ready, m_axi_valid, m_axi_last,
    output src_ready, cfg_valid, cfg_inverse, s_axi_valid, s_axi_data, s_axi_last
  );

  modport slave (
    output src_valid, src_data, cfg_ready, s_axi_ready, m_axi_valid, m_axi_last,
    input  src_ready, cfg_valid, cfg_inverse, s_axi_valid, s_axi_data, s_axi_last
  );
endinterface

// File: rtl/fft_frame_sched.sv
// Frame scheduler in front of a burst FFT/IFFT core. Gates the sample source
// into the core one FFT_LENGTH frame at a time, issuing a direction config
// before each frame and marking the final sample with s_axi_last. Frames in
// flight are tracked from the core's output last beats; new frames stall
// while MAX_INFLIGHT frames are outstanding.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   mode_inverse    : requested direction (1 = IFFT), latched on entry to CFG
//   bus (master)    : source / config / core-input / core-output handshakes
//   inflight        : frames accepted by the core but not yet output
//   frame_done      : one-cycle pulse the cycle after each output last
//   busy            : not IDLE, or frames still in flight
//   err_underflow   : sticky, output last seen with nothing in flight
module fft_frame_sched #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 9,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode_inverse,
  fft_frame_sched_if.master  bus,
  output logic [1:0]         inflight,
  output logic               frame_done,
  output logic               busy,
  output logic               err_underflow
);

  localparam int unsigned    CW         = ADDR_WIDTH + 1;
  localparam int unsigned    FFT_LENGTH = 1 << CW;
  localparam logic [CW-1:0]  CNT_LAST   = CW'(FFT_LENGTH - 1);
  localparam logic [1:0]     IF_MAX     = 2'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CFG,
    ST_LOAD
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      inflight_q, inflight_d;
  logic            cfg_inverse_q, cfg_inverse_d;
  logic            frame_done_q, frame_done_d;
  logic            err_underflow_q, err_underflow_d;

  logic            cfg_valid_c;
  logic            src_ready_c;
  logic            s_valid_c;
  logic            s_last_c;
  logic            commit_c;
  logic            out_last_c;
  logic            dec_c;
  logic [2*DATA_WIDTH-1:0] sample_c;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    cfg_inverse_d   = cfg_inverse_q;
    cfg_valid_c     = 1'b0;
    src_ready_c     = 1'b0;
    s_valid_c       = 1'b0;
    s_last_c        = 1'b0;
    commit_c        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (inflight_q < IF_MAX) begin
          state_d       = ST_CFG;
          cfg_inverse_d = mode_inverse;
        end
      end
      ST_CFG: begin
        cfg_valid_c = 1'b1;
        if (bus.cfg_ready) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        s_valid_c   = bus.src_valid;
        src_ready_c = bus.s_axi_ready;
        s_last_c    = (cnt_q == CNT_LAST);
        if (bus.src_valid && bus.s_axi_ready) begin
          cnt_d = cnt_q + CW'(1);
          if (s_last_c) begin
            commit_c = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An output last with nothing in flight is flagged rather than counted,
    // so the counter never wraps below zero.
    out_last_c      = bus.m_axi_valid & bus.m_axi_last;
    dec_c           = out_last_c && (inflight_q != '0);
    inflight_d      = inflight_q;
    if (commit_c && !dec_c) begin
      inflight_d = inflight_q + 2'd1;
    end else if (!commit_c && dec_c) begin
      inflight_d = inflight_q - 2'd1;
    end
    frame_done_d    = out_last_c;
    err_underflow_d = err_underflow_q | (out_last_c && (inflight_q == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      inflight_q      <= '0;
      cfg_inverse_q   <= 1'b0;
      frame_done_q    <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      inflight_q      <= inflight_d;
      cfg_inverse_q   <= cfg_inverse_d;
      frame_done_q    <= frame_done_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  // Data is a straight pass-through; its value outside LOAD is irrelevant.
  assign sample_c        = bus.src_data;
  assign bus.s_axi_data  = sample_c;
  assign bus.s_axi_valid = s_valid_c;
  assign bus.s_axi_last  = s_last_c;
  assign bus.src_ready   = src_ready_c;
  assign bus.cfg_valid   = cfg_valid_c;
  assign bus.cfg_inverse = cfg_inverse_q;

  assign inflight        = inflight_q;
  assign frame_done      = frame_done_q;
  assign busy            = (state_q != ST_IDLE) || (inflight_q != '0);
  assign err_underflow   = err_underflow_q;

endmodule

// File: doc/fft_frame_sched.md
# fft_frame_sched

Frame scheduler in front of the burst FFT/IFFT core. It gates a streaming complex-sample source into the core's input AXI-stream one `FFT_LENGTH` frame at a time. Before each frame it issues a per-frame direction config (FFT/IFFT) and inserts `s_axi_last` on the final sample. It tracks frames in flight by watching the core's output `m_axi_valid & m_axi_last`, and stalls new frames once `MAX_INFLIGHT` is reached.

## Interface
Parameters:
- `DATA_WIDTH`, 16: real/imag component width; sample bus is `2*DATA_WIDTH`.
- `ADDR_WIDTH`, 9: sets `FFT_LENGTH = 2**(ADDR_WIDTH+1)` (1024 at default).
- `MAX_INFLIGHT`, 2: maximum frames accepted by the core but not yet fully output (1..3).

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode_inverse`  in  1  requested direction (1 = IFFT); sampled on entry to CFG.
- `src_valid`  in  1  source sample valid.
- `src_data`  in  2*DATA_WIDTH  source sample {imag, real}.
- `src_ready`  out  1  source sample accepted when `src_valid & src_ready`.
- `cfg_valid`  out  1  config word valid.
- `cfg_inverse`  out  1  config direction, stable while `cfg_valid`.
- `cfg_ready`  in  1  core config ready.
- `s_axi_valid`  out  1  core input valid.
- `s_axi_data`  out  2*DATA_WIDTH  core input sample.
- `s_axi_last`  out  1  final sample of the frame.
- `s_axi_ready`  in  1  core input ready.
- `m_axi_valid`  in  1  core output valid (monitor only).
- `m_axi_last`  in  1  core output last (monitor only).
- `inflight`  out  2  frames in flight.
- `frame_done`  out  1  one-cycle pulse per completed output frame.
- `busy`  out  1  high in any state other than IDLE, or while `inflight != 0`.
- `err_underflow`  out  1  sticky: output last seen while `inflight == 0`.

## Operation
- FSM states are IDLE, CFG and LOAD. The state is registered and outputs are decoded from it.
- **IDLE:** on `inflight < MAX_INFLIGHT`, go to CFG next cycle and latch `mode_inverse` into `cfg_inverse`. Otherwise stay in IDLE.
- **CFG:** `cfg_valid=1`. On `cfg_valid & cfg_ready`, go to LOAD and clear the sample counter `cnt` (width `ADDR_WIDTH+1`).
- **LOAD:** combinational pass-through with no extra cycles on the data path:
  - `s_axi_valid = src_valid`
  - `src_ready = s_axi_ready`
  - `s_axi_data = src_data`
  - `s_axi_last = (cnt == FFT_LENGTH-1)`
- A transfer is `src_valid & s_axi_ready`; each transfer increments `cnt`.
- When a transfer occurs with `s_axi_last`, the frame is committed and the FSM returns to IDLE. The counter wraps to 0 naturally.
- Outside LOAD: `src_ready=0`, `s_axi_valid=0`, `s_axi_last=0`. `s_axi_data` is don't-care.
- **`inflight` update:**
  - +1 on frame commit.
  - −1 on `m_axi_valid & m_axi_last` when `inflight > 0`.
  - Both events in the same cycle: unchanged.
- **`m_axi_valid & m_axi_last` with `inflight == 0`:** the count stays 0, `err_underflow` sets and stays set until reset, and `frame_done` is still pulsed.
- **`frame_done`:** registered, high the cycle after each `m_axi_valid & m_axi_last`.
- **Reset (any time, including mid-frame):** state goes to IDLE and `cnt`/`inflight` clear. A partially sent frame is abandoned; the core must be reset alongside.

## Timing
- Reset values: `src_ready=0`, `cfg_valid=0`, `cfg_inverse=0`, `s_axi_valid=0`, `s_axi_last=0`, `inflight=0`, `frame_done=0`, `busy=0`, `err_underflow=0`.
- First `cfg_valid` appears at the 2nd rising edge after reset release: IDLE → CFG takes 1 cycle.
- Per-frame overhead: 1 cycle in IDLE, plus CFG cycles (≥1) until `cfg_ready`. Transfers start in the cycle after the config handshake.
- Frame period at full throughput: `FFT_LENGTH + 2` cycles.
- `cfg_valid`/`cfg_inverse` are held until the handshake completes. Changes on `mode_inverse` have no effect after entry to CFG.
- `inflight` is visible the cycle after a commit or output last. An IDLE decision uses the registered value, so a slot freed in cycle t allows CFG at t+2.

## Test plan
- **Single frame:** `cfg_ready=1`, `s_axi_ready=1`, continuous `src_valid` → `cfg_valid` pulses 1 cycle, then exactly 1024 transfers. `s_axi_last` is high only on the 1024th. `inflight` goes 0→1.
- **Backpressure:** toggle `s_axi_ready` 50% and `src_valid` randomly → no sample is lost or duplicated, `s_axi_last` lands on the 1024th accepted sample, and `src_ready` mirrors `s_axi_ready` in LOAD.
- **Inflight limit:** never drive `m_axi_last` → after 2 frames the FSM stays in IDLE, `cfg_valid=0`. One `m_axi_valid & m_axi_last` → `frame_done` pulses, `inflight` goes 2→1, and `cfg_valid` rises 2 cycles later.
- **Simultaneous events:** output last in the same cycle as an input commit with `inflight=1` → `inflight` stays 1 and `frame_done` pulses.
- **Underflow:** `m_axi_valid & m_axi_last` at `inflight=0` → `err_underflow=1` (sticky) and `inflight=0`.
- **Reset mid-frame:** assert `rst_n=0` at sample 500 → all outputs at reset values immediately. After release, the next frame again carries exactly 1024 samples with a fresh config, with `cfg_inverse` following `mode_inverse`.
